j2_imem_loader: RTL
===================

// Module: j2_imem_loader
// PURPOSE
//   Instruction memory plus byte-stream boot loader that feeds the j2 core's
//   instruction fetch port. After reset it holds the core in reset and accepts
//   an image over a valid/ready byte stream, then releases the core.
//   Once released, it serves 16-bit instructions with 1-cycle synchronous read
//   latency from the core's 13-bit next-PC address.
// PARAMETERS
//   ADDR_WIDTH  13  instruction word address width; must be 13 for the j2 core
//   WORD_WIDTH  16  instruction width; byte assembly is fixed at 2 bytes/word
// PORTS
//   clock                input   1   system clock, all state on posedge
//   active_low_reset     input   1   asynchronous, active-low reset
//   rx_data              input   8   loader byte
//   rx_valid             input   1   rx_data valid
//   rx_ready             output  1   loader can accept a byte this cycle
//   instruction_address  input   13  core fetch address (core's next PC)
//   instruction          output  16  registered fetch data, 1 cycle after address
//   core_reset_n         output  1   reset to the core, 0 = core held in reset
//   boot_done            output  1   image loaded, core running
//   load_error           output  1   malformed image, sticky until reset
// BEHAVIOUR
//   Reset values: rx_ready=1, core_reset_n=0, boot_done=0, load_error=0,
//   instruction=16'h0000, state=HDR_LO, write pointer=0, word count=0.
//   Memory contents are not cleared by reset.
//   Byte transfer: a byte is accepted on a posedge with rx_valid&&rx_ready.
//   rx_ready is decoded from registered state: 1 in HDR_LO/HDR_HI/DATA_LO/DATA_HI
//   (and CHECK when enabled), otherwise 0.
//   Image format, little-endian: count[7:0], count[15:8], then count words,
//   each sent as lo byte then hi byte.
//   States:
//   - HDR_LO -> HDR_HI on accept; latch count lo byte.
//   - HDR_HI -> DATA_LO on accept; latch count hi byte.
//     Go to ERROR instead if count==0 or count>2**ADDR_WIDTH.
//   - DATA_LO -> DATA_HI on accept; latch lo byte.
//   - DATA_HI on accept: write {hi,lo} to mem[wptr] and increment wptr.
//     If wptr==count-1, go to CHECK (macro on) or RUN (macro off);
//     otherwise go to DATA_LO.
//   - RUN: terminal. core_reset_n=1, boot_done=1, rx_ready=0, no more writes.
//   - ERROR: terminal. load_error=1, core_reset_n=0, rx_ready=0.
//   core_reset_n/boot_done are registered; they go high on the same edge that
//   enters RUN. Only active_low_reset leaves RUN or ERROR.
//   Read port: instruction <= mem[instruction_address] every posedge, in all
//   states. Same-cycle write/read to one address returns the old data.
//   count==8192 loads the full memory; wptr stops at 8191 and does not wrap.
//   Reset mid-load: returns to HDR_LO immediately and drops core_reset_n
//   asynchronously. Partially written words remain in memory.
//   A DATA_LO byte with no following hi byte stalls in DATA_HI indefinitely;
//   there is no timeout.
// CONFIGURATION
//   J2_LOADER_CHECKSUM_EN defined:
//   - Adds a CHECK state after the last word; one more byte is accepted there.
//   - Pass condition: that byte == 8-bit modulo sum of all 2*count payload bytes.
//   - Match -> RUN. Mismatch -> ERROR (image stays in memory, core held in reset).
//   - Header bytes are excluded from the sum.
//   Undefined: no CHECK state and no sum register; last DATA_HI goes to RUN.
// STRUCTURE
//   Shared package j2_loader_pkg:
//   - state encoding (HDR_LO, HDR_HI, DATA_LO, DATA_HI, CHECK, RUN, ERROR)
//   - IMEM_WORDS = 2**ADDR_WIDTH, BYTES_PER_WORD = 2
//   Sub-module j2_imem_ram: 1 write port, 1 synchronous read port,
//   ADDR_WIDTH x WORD_WIDTH, read-before-write. Loader FSM lives in the top.
// TESTING
//   1. Reset, stream 03 00 | 34 12 | 78 56 | BC 9A -> mem[0..2]=1234,5678,9ABC;
//      boot_done=1 and core_reset_n=1 on the edge accepting byte 0xBC.
//   2. After RUN, drive instruction_address=1 -> instruction=16'h5678 on the
//      next posedge; rx_ready=0, and extra bytes write nothing.
//   3. Header 00 00 -> load_error=1, rx_ready=0, core_reset_n stays 0.
//      Header 01 20 (count 8193) -> same result.
//   4. Stall test: rx_valid toggled randomly during a 4-word load -> identical
//      memory contents and no byte lost or duplicated.
//   5. Assert reset after 3 payload bytes, then reload 01 00 EF BE
//      -> mem[0]=BEEF, boot_done=1.
//   6. Checksum on: image 01 00 34 12 then 46 -> RUN;
//      same image then 47 -> ERROR with load_error=1.

Source files
------------

// File: rtl/j2_loader_pkg.sv
// Shared definitions for the j2 instruction memory and boot loader.
// Loader state encoding and memory geometry constants.
package j2_loader_pkg;

    localparam int IMEM_ADDR_WIDTH = 13;
    localparam int IMEM_WORD_WIDTH = 16;
    localparam int IMEM_WORDS      = 2 ** IMEM_ADDR_WIDTH;
    localparam int BYTES_PER_WORD  = 2;

    typedef enum logic [2:0] {
        HDR_LO  = 3'd0,
        HDR_HI  = 3'd1,
        DATA_LO = 3'd2,
        DATA_HI = 3'd3,
        CHECK   = 3'd4,
        RUN     = 3'd5,
        ERROR   = 3'd6
    } loader_state_e;

endpackage

// File: rtl/j2_imem_ram.sv
// Single write port, single registered read port instruction RAM.
// A read of the address being written in the same cycle returns the old word.
module j2_imem_ram #(
    parameter int ADDR_WIDTH = 13,
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  active_low_reset,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [WORD_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [WORD_WIDTH-1:0] rdata_o
);

    logic [WORD_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [WORD_WIDTH-1:0] rdata_q;

    // Array has no reset so it can map onto block RAM; contents survive reset.
    always_ff @(posedge clock) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clock or negedge active_low_reset) begin
        if (!active_low_reset) rdata_q <= '0;
        else                   rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/j2_imem_loader.sv
// j2 instruction memory with byte-stream boot loader; holds the core in reset
// until an image is loaded. Optional trailing checksum byte: J2_LOADER_CHECKSUM_EN.
module j2_imem_loader
    import j2_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter int WORD_WIDTH = IMEM_WORD_WIDTH
) (
    input  logic                  clock,
    input  logic                  active_low_reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic [ADDR_WIDTH-1:0] instruction_address,
    output logic [WORD_WIDTH-1:0] instruction,
    output logic                  core_reset_n,
    output logic                  boot_done,
    output logic                  load_error
);

    localparam logic [16:0] MAX_COUNT = 17'(2 ** ADDR_WIDTH);

    loader_state_e         state_q, state_d;
    logic [15:0]           count_q, count_d;
    logic [7:0]            lo_q, lo_d;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic                  core_rst_n_q, core_rst_n_d;
    logic                  boot_done_q, boot_done_d;
    logic                  load_error_q, load_error_d;
`ifdef J2_LOADER_CHECKSUM_EN
    logic [7:0]            sum_q, sum_d;
`endif

    logic                  accept;
    logic                  mem_we;
    logic [WORD_WIDTH-1:0] mem_wdata;
    logic [15:0]           hdr_count;
    logic                  hdr_bad;
    logic                  last_word;

    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            HDR_LO, HDR_HI, DATA_LO, DATA_HI: rx_ready = 1'b1;
`ifdef J2_LOADER_CHECKSUM_EN
            CHECK:                            rx_ready = 1'b1;
`endif
            default:                          rx_ready = 1'b0;
        endcase
    end

    assign accept    = rx_valid && rx_ready;
    assign hdr_count = {rx_data, count_q[7:0]};
    assign hdr_bad   = (hdr_count == 16'd0) || ({1'b0, hdr_count} > MAX_COUNT);
    // count is at least 1 once in the data states, so count-1 cannot underflow.
    assign last_word = (16'(wptr_q) == (count_q - 16'd1));

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        lo_d      = lo_q;
        wptr_d    = wptr_q;
        mem_we    = 1'b0;
        mem_wdata = {rx_data, lo_q};
`ifdef J2_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        case (state_q)
            HDR_LO: if (accept) begin
                count_d[7:0] = rx_data;
                state_d      = HDR_HI;
            end
            HDR_HI: if (accept) begin
                count_d[15:8] = rx_data;
                state_d       = hdr_bad ? ERROR : DATA_LO;
            end
            DATA_LO: if (accept) begin
                lo_d    = rx_data;
`ifdef J2_LOADER_CHECKSUM_EN
                sum_d   = sum_q + rx_data;
`endif
                state_d = DATA_HI;
            end
            DATA_HI: if (accept) begin
                mem_we = 1'b1;
`ifdef J2_LOADER_CHECKSUM_EN
                sum_d  = sum_q + rx_data;
`endif
                // Pointer parks on the final word so a full-size image never wraps.
                if (last_word) begin
`ifdef J2_LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = RUN;
`endif
                end else begin
                    wptr_d  = wptr_q + 1'b1;
                    state_d = DATA_LO;
                end
            end
`ifdef J2_LOADER_CHECKSUM_EN
            CHECK: if (accept) begin
                state_d = (rx_data == sum_q) ? RUN : ERROR;
            end
`endif
            RUN:     state_d = RUN;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase

        core_rst_n_d = (state_d == RUN);
        boot_done_d  = (state_d == RUN);
        load_error_d = (state_d == ERROR);
    end

    always_ff @(posedge clock or negedge active_low_reset) begin
        if (!active_low_reset) begin
            state_q      <= HDR_LO;
            count_q      <= '0;
            lo_q         <= '0;
            wptr_q       <= '0;
            core_rst_n_q <= 1'b0;
            boot_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            lo_q         <= lo_d;
            wptr_q       <= wptr_d;
            core_rst_n_q <= core_rst_n_d;
            boot_done_q  <= boot_done_d;
            load_error_q <= load_error_d;
        end
    end

`ifdef J2_LOADER_CHECKSUM_EN
    always_ff @(posedge clock or negedge active_low_reset) begin
        if (!active_low_reset) sum_q <= '0;
        else                   sum_q <= sum_d;
    end
`endif

    assign core_reset_n = core_rst_n_q;
    assign boot_done    = boot_done_q;
    assign load_error   = load_error_q;

    j2_imem_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_ram (
        .clock            (clock),
        .active_low_reset (active_low_reset),
        .we_i             (mem_we),
        .waddr_i          (wptr_q),
        .wdata_i          (mem_wdata),
        .raddr_i          (instruction_address),
        .rdata_o          (instruction)
    );

endmodule
